// File: rtl/machine_timer_pkg.sv
// Shared constants for the machine timer: register offsets (word index) and the default window base.
// The base matches the address the CSR controller redirects TIME/TIME_H loads to.
package machine_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h8100_0000;

    // Word index within the 32-byte window, i.e. address[4:2]
    localparam logic [2:0] MTIME_LO    = 3'd0;
    localparam logic [2:0] MTIME_HI    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO = 3'd2;
    localparam logic [2:0] MTIMECMP_HI = 3'd3;
    localparam logic [2:0] MSIP        = 3'd4;

endpackage

// File: rtl/machine_timer_if.sv
// Data-memory bus slice seen by the machine timer: single-cycle select strobe, registered load data.
// No ready/wait state; every selected access completes.
interface machine_timer_if;
    logic        select;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output select, write, address, byte_enable, write_data,
        input  read_data
    );

    modport slave (
        input  select, write, address, byte_enable, write_data,
        output read_data
    );
endinterface

// File: rtl/machine_timer_prescaler.sv
// Prescaler for mtime: tick is high one cycle in every TICK_DIVIDER, the first one TICK_DIVIDER cycles after reset.
// Latency: tick is combinational from the registered count; no backpressure.
module timer_prescaler #(
    parameter int TICK_DIVIDER = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam logic [15:0] LAST_COUNT = 16'(TICK_DIVIDER - 1);

    logic [15:0] tick_count;

    assign tick = (tick_count == LAST_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_count <= 16'd0;
        end else if (tick) begin
            tick_count <= 16'd0;
        end else begin
            tick_count <= tick_count + 16'd1;
        end
    end
endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime, mtimecmp and msip behind a 32-byte window.
// Loads and stores take 1 cycle, no backpressure; timer interrupt is a registered mtime >= mtimecmp.
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter int          TICK_DIVIDER = 1
) (
    input  logic            clock,
    input  logic            reset,
    machine_timer_if.slave  bus,
    output logic            pad_timer_interrupt,
    output logic            pad_software_interrupt
);
    logic [63:0] mtime;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] read_data_q;
    logic        timer_irq;
    logic        tick;

    logic        hit;
    logic        store_hit;
    logic        load_hit;
    logic [2:0]  reg_sel;
    logic [31:0] reg_word;
    logic [31:0] merged_word;
    logic        unused_address_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    timer_prescaler #(
        .TICK_DIVIDER (TICK_DIVIDER)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign unused_address_bits = ^bus.address[1:0];

    assign hit       = bus.select && (bus.address[31:5] == BASE_ADDRESS[31:5]);
    // A store with no lanes enabled is treated as no store at all, so it cannot suppress a tick.
    assign store_hit = hit && bus.write && (bus.byte_enable != 4'd0);
    assign load_hit  = hit && !bus.write;
    assign reg_sel   = bus.address[4:2];

    always_comb begin
        reg_word = 32'd0;
        case (reg_sel)
            MTIME_LO:    reg_word = mtime[31:0];
            MTIME_HI:    reg_word = mtime[63:32];
            MTIMECMP_LO: reg_word = mtimecmp[31:0];
            MTIMECMP_HI: reg_word = mtimecmp[63:32];
            MSIP:        reg_word = {31'd0, msip};
            default:     reg_word = 32'd0;
        endcase
    end

    assign merged_word = merge_bytes(reg_word, bus.write_data, bus.byte_enable);

    // A store to either mtime half takes the whole cycle; the tick is dropped.
    always_comb begin
        mtime_next = mtime;
        if (store_hit && reg_sel == MTIME_LO) begin
            mtime_next[31:0] = merged_word;
        end else if (store_hit && reg_sel == MTIME_HI) begin
            mtime_next[63:32] = merged_word;
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime       <= 64'd0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            read_data_q <= 32'd0;
            timer_irq   <= 1'b0;
        end else begin
            mtime     <= mtime_next;
            timer_irq <= (mtime >= mtimecmp);
            if (load_hit) begin
                read_data_q <= reg_word;
            end
            if (store_hit) begin
                case (reg_sel)
                    MTIMECMP_LO: mtimecmp[31:0]  <= merged_word;
                    MTIMECMP_HI: mtimecmp[63:32] <= merged_word;
                    MSIP:        msip            <= merged_word[0];
                    default:     ;
                endcase
            end
        end
    end

    assign bus.read_data          = read_data_q;
    assign pad_timer_interrupt    = timer_irq;
    assign pad_software_interrupt = msip;
endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: one DUT per divider (1 and 4) driven with identical bus traffic,
// each checked every cycle against a behavioural model plus directed expectations.
module tb_machine_timer;
    localparam logic [31:0] BASE = 32'h8100_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic irq1, sip1, irq4, sip4;

    machine_timer_if bus1 ();
    machine_timer_if bus4 ();

    machine_timer #(.BASE_ADDRESS(BASE), .TICK_DIVIDER(1)) dut1 (
        .clock (clock), .reset (reset), .bus (bus1),
        .pad_timer_interrupt (irq1), .pad_software_interrupt (sip1)
    );
    machine_timer #(.BASE_ADDRESS(BASE), .TICK_DIVIDER(4)) dut4 (
        .clock (clock), .reset (reset), .bus (bus4),
        .pad_timer_interrupt (irq4), .pad_software_interrupt (sip4)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, index 0 = divider 1, index 1 = divider 4
    int          divs [2] = '{1, 4};
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];
    logic        m_sip  [2];
    int          m_cyc  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] apply_lanes(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = '1;
            m_rd[k]   = 32'd0;
            m_irq[k]  = 1'b0;
            m_sip[k]  = 1'b0;
            m_cyc[k]  = 0;
        end
    endtask

    // One clock edge of the architectural behaviour, computed from the pre-edge state
    task automatic model_edge(input int k, input logic s, input logic w, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
        logic [63:0] t, c;
        logic        act, tick, time_store;
        int          word;
        t    = m_time[k];
        c    = m_cmp[k];
        act  = s && (a[31:5] == BASE[31:5]);
        word = int'(a[4:2]);
        tick = (m_cyc[k] % divs[k]) == (divs[k] - 1);
        m_cyc[k]++;
        m_irq[k] = (t >= c);
        if (act && !w) begin
            case (word)
                0:       m_rd[k] = t[31:0];
                1:       m_rd[k] = t[63:32];
                2:       m_rd[k] = c[31:0];
                3:       m_rd[k] = c[63:32];
                4:       m_rd[k] = {31'd0, m_sip[k]};
                default: m_rd[k] = 32'd0;
            endcase
        end
        time_store = act && w && (be != 4'd0) && (word <= 1);
        if (!time_store && tick) m_time[k] = t + 64'd1;
        if (act && w && be != 4'd0) begin
            case (word)
                0: m_time[k][31:0]  = apply_lanes(t[31:0], wd, be);
                1: m_time[k][63:32] = apply_lanes(t[63:32], wd, be);
                2: m_cmp[k][31:0]   = apply_lanes(c[31:0], wd, be);
                3: m_cmp[k][63:32]  = apply_lanes(c[63:32], wd, be);
                4: if (be[0]) m_sip[k] = wd[0];
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        check("rd_div1",  {32'd0, bus1.read_data}, {32'd0, m_rd[0]});
        check("irq_div1", {63'd0, irq1}, {63'd0, m_irq[0]});
        check("sip_div1", {63'd0, sip1}, {63'd0, m_sip[0]});
        check("rd_div4",  {32'd0, bus4.read_data}, {32'd0, m_rd[1]});
        check("irq_div4", {63'd0, irq4}, {63'd0, m_irq[1]});
        check("sip_div4", {63'd0, sip4}, {63'd0, m_sip[1]});
    endtask

    task automatic bus(input logic s, input logic w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
        bus1.select = s; bus1.write = w; bus1.address = a; bus1.byte_enable = be; bus1.write_data = wd;
        bus4.select = s; bus4.write = w; bus4.address = a; bus4.byte_enable = be; bus4.write_data = wd;
        @(posedge clock);
        model_edge(0, s, w, a, be, wd);
        model_edge(1, s, w, a, be, wd);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic load(input logic [4:0] off);
        bus(1'b1, 1'b0, BASE + {27'd0, off}, 4'd0, 32'd0);
    endtask

    task automatic store(input logic [4:0] off, input logic [31:0] d, input logic [3:0] be);
        bus(1'b1, 1'b1, BASE + {27'd0, off}, be, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  off;

        bus1.select = 0; bus1.write = 0; bus1.address = 0; bus1.byte_enable = 0; bus1.write_data = 0;
        bus4.select = 0; bus4.write = 0; bus4.address = 0; bus4.byte_enable = 0; bus4.write_data = 0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_rd",  {32'd0, bus1.read_data}, 64'd0);
        check("reset_irq", {63'd0, irq1}, 64'd0);
        check("reset_sip", {63'd0, sip1}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Free-running count after reset
        idle(10);
        load(5'h00);
        check("count10_div1", {32'd0, bus1.read_data}, 64'd10);
        check("count10_div4", {32'd0, bus4.read_data}, 64'd2);
        check("count10_noirq", {63'd0, irq1}, 64'd0);

        // Carry from low into high half
        store(5'h00, 32'hFFFF_FFFF, 4'hF);
        store(5'h04, 32'h0, 4'hF);
        idle(1);
        load(5'h00);
        check("carry_lo", {32'd0, bus1.read_data}, 64'd0);
        load(5'h04);
        check("carry_hi", {32'd0, bus1.read_data}, 64'd1);

        // Compare match: irq rises one cycle after mtime reaches 0x14, falls one cycle after cmp raised
        store(5'h04, 32'h0, 4'hF);
        store(5'h00, 32'h10, 4'hF);
        store(5'h08, 32'h14, 4'hF);
        store(5'h0C, 32'h0, 4'hF);
        idle(2);
        check("cmp_before", {63'd0, irq1}, 64'd0);
        idle(1);
        check("cmp_rise", {63'd0, irq1}, 64'd1);
        store(5'h0C, 32'hFFFF_FFFF, 4'hF);
        check("cmp_lag", {63'd0, irq1}, 64'd1);
        idle(1);
        check("cmp_fall", {63'd0, irq1}, 64'd0);

        // Software interrupt and byte masking
        store(5'h10, 32'h1, 4'hF);
        check("msip_set", {63'd0, sip1}, 64'd1);
        load(5'h10);
        check("msip_read", {32'd0, bus1.read_data}, 64'd1);
        store(5'h10, 32'h0, 4'b0010);
        check("msip_masked", {63'd0, sip1}, 64'd1);
        store(5'h14, 32'hDEAD_BEEF, 4'hF);
        load(5'h14);
        check("reserved_zero", {32'd0, bus1.read_data}, 64'd0);

        // Divider 4: store lands on a tick edge, next increment 4 cycles later
        while ((m_cyc[1] % 4) != 3) idle(1);
        store(5'h00, 32'hAB, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            load(5'h00);
            check($sformatf("div4_store_tick_%0d", i), {32'd0, bus4.read_data},
                  (i >= 5) ? 64'hAC : 64'hAB);
        end

        // Asynchronous reset mid-count, between edges
        store(5'h0C, 32'h0, 4'hF);
        store(5'h08, 32'h0, 4'hF);
        idle(2);
        check("pre_reset_irq", {63'd0, irq1}, 64'd1);
        idle(1);
        #2 reset = 1'b1;
        #1;
        check("async_rd1",  {32'd0, bus1.read_data}, 64'd0);
        check("async_irq1", {63'd0, irq1}, 64'd0);
        check("async_sip1", {63'd0, sip1}, 64'd0);
        check("async_rd4",  {32'd0, bus4.read_data}, 64'd0);
        check("async_irq4", {63'd0, irq4}, 64'd0);
        check("async_sip4", {63'd0, sip4}, 64'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        reset = 1'b0;
        load(5'h08);
        check("cmp_lo_reset", {32'd0, bus1.read_data}, 64'hFFFF_FFFF);
        load(5'h0C);
        check("cmp_hi_reset", {32'd0, bus4.read_data}, 64'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            off = 5'($urandom_range(0, 7) * 4);
            a   = BASE + {27'd0, off};
            if ($urandom_range(0, 7) == 0) a = a + 32'h20;
            if ($urandom_range(0, 15) == 0) a = a ^ 32'h1000_0000;
            bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                (off == 5'h0C || off == 5'h04) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 600)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
